// File: rtl/cls_pkg.sv
// Shared types and constants for the spike-count classification controller.
package cls_pkg;

    localparam int CNT_W         = 3;
    localparam int SETTLE_CYCLES = 2;
    localparam int WINDOW_DEF    = 16;
    localparam int THRESH_DEF    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SETTLE,
        ST_DECIDE,
        ST_DONE
    } cls_state_t;

endpackage

// File: rtl/cls_delta.sv
// Modulo-8 spike counts against the start-of-window baselines, with winner/tie compare
// and the early-exit threshold hit (comparator only built when CLS_EARLY_EXIT_EN is defined).
module cls_delta
    import cls_pkg::*;
`ifdef CLS_EARLY_EXIT_EN
#(
    parameter int THRESH = THRESH_DEF
)
`endif
(
    input  logic [CNT_W-1:0] pot1_i,
    input  logic [CNT_W-1:0] pot2_i,
    input  logic [CNT_W-1:0] base1_i,
    input  logic [CNT_W-1:0] base2_i,
    output logic [CNT_W-1:0] d1_o,
    output logic [CNT_W-1:0] d2_o,
    output logic             gt_o,
    output logic             eq_o,
    output logic             hit_o
);

    // Potentials wrap modulo 8, so a plain 3-bit subtraction yields the event count.
    assign d1_o = pot1_i - base1_i;
    assign d2_o = pot2_i - base2_i;
    assign gt_o = (d2_o > d1_o);
    assign eq_o = (d1_o == d2_o);

`ifdef CLS_EARLY_EXIT_EN
    assign hit_o = (d1_o >= CNT_W'(THRESH)) || (d2_o >= CNT_W'(THRESH));
`else
    assign hit_o = 1'b0;
`endif

endmodule

// File: rtl/classify_ctrl.sv
// Inference-window sequencer: RUN -> SETTLE -> DECIDE -> DONE with a valid/ready result.
// Optional early exit on a threshold spike count is enabled by CLS_EARLY_EXIT_EN.
module classify_ctrl
    import cls_pkg::*;
#(
    parameter int WINDOW = WINDOW_DEF,
    parameter int THRESH = THRESH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] potential1_s,
    input  logic [CNT_W-1:0] potential2_s,
    output logic             en_s,
    output logic             busy,
    output logic             cls_valid,
    input  logic             cls_ready,
    output logic             cls_id,
    output logic             cls_tie,
    output logic [CNT_W-1:0] cls_cnt1,
    output logic [CNT_W-1:0] cls_cnt2,
    output logic             cls_early
);

    // Result handshake: cls_valid is high for the whole DONE state and all result
    // outputs are stable while it is high; the transfer happens on an edge where
    // cls_valid && cls_ready, and cls_ready alone has no effect.

    if (WINDOW < 1 || WINDOW > 255 || THRESH < 1 || THRESH > 7) begin : g_param_check
        $error("classify_ctrl: WINDOW must be 1..255 and THRESH 1..7");
    end

    localparam logic [7:0] WIN_LAST    = 8'(WINDOW - 1);
    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

    cls_state_t       state_q, state_d;
    logic [7:0]       win_q, win_d;
    logic [1:0]       settle_q, settle_d;
    logic [CNT_W-1:0] base1_q, base1_d, base2_q, base2_d;
    logic             run_early_q, run_early_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic             id_q, id_d, tie_q, tie_d, early_q, early_d;

    logic [CNT_W-1:0] d1, d2;
    logic             gt, eq, hit;

    cls_delta
`ifdef CLS_EARLY_EXIT_EN
    #(.THRESH(THRESH))
`endif
    u_delta (
        .pot1_i  (potential1_s),
        .pot2_i  (potential2_s),
        .base1_i (base1_q),
        .base2_i (base2_q),
        .d1_o    (d1),
        .d2_o    (d2),
        .gt_o    (gt),
        .eq_o    (eq),
        .hit_o   (hit)
    );

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        settle_d    = settle_q;
        base1_d     = base1_q;
        base2_d     = base2_q;
        run_early_d = run_early_q;
        cnt1_d      = cnt1_q;
        cnt2_d      = cnt2_q;
        id_d        = id_q;
        tie_d       = tie_q;
        early_d     = early_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base1_d     = potential1_s;
                    base2_d     = potential2_s;
                    win_d       = 8'd0;
                    run_early_d = 1'b0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                win_d = win_q + 8'd1;
                // A threshold hit on the last window cycle still marks the result early.
                if (hit || win_q == WIN_LAST) begin
                    settle_d    = 2'd0;
                    run_early_d = hit;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                settle_d = settle_q + 2'd1;
                if (settle_q == SETTLE_LAST) begin
                    state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                cnt1_d  = d1;
                cnt2_d  = d2;
                tie_d   = eq;
                id_d    = gt;
                early_d = run_early_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (cls_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            win_q       <= 8'd0;
            settle_q    <= 2'd0;
            base1_q     <= '0;
            base2_q     <= '0;
            run_early_q <= 1'b0;
            cnt1_q      <= '0;
            cnt2_q      <= '0;
            id_q        <= 1'b0;
            tie_q       <= 1'b0;
            early_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            settle_q    <= settle_d;
            base1_q     <= base1_d;
            base2_q     <= base2_d;
            run_early_q <= run_early_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
            id_q        <= id_d;
            tie_q       <= tie_d;
            early_q     <= early_d;
        end
    end

    assign en_s      = (state_q == ST_RUN);
    assign busy      = (state_q != ST_IDLE);
    assign cls_valid = (state_q == ST_DONE);
    assign cls_id    = id_q;
    assign cls_tie   = tie_q;
    assign cls_cnt1  = cnt1_q;
    assign cls_cnt2  = cnt2_q;
    assign cls_early = early_q;

endmodule

// File: tb/tb_classify_ctrl.sv
// Bench for classify_ctrl: timeline reference model, per-cycle compare, result queue,
// directed scenarios with literal expectations, then randomized traffic.
module tb_classify_ctrl;

    localparam int W  = 16;
    localparam int TH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cls_ready = 1'b0;
    logic [2:0] potential1_s = 3'd0;
    logic [2:0] potential2_s = 3'd0;
    logic       en_s, busy, cls_valid, cls_id, cls_tie, cls_early;
    logic [2:0] cls_cnt1, cls_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    classify_ctrl #(.WINDOW(W), .THRESH(TH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .potential1_s (potential1_s),
        .potential2_s (potential2_s),
        .en_s         (en_s),
        .busy         (busy),
        .cls_valid    (cls_valid),
        .cls_ready    (cls_ready),
        .cls_id       (cls_id),
        .cls_tie      (cls_tie),
        .cls_cnt1     (cls_cnt1),
        .cls_cnt2     (cls_cnt2),
        .cls_early    (cls_early)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Timeline view: a window accepted at edge ts runs until edge re (ts+W, or earlier on
    // an early exit); the result is taken from the potentials at edge re+3.
    int         cyc = 0;
    int         re = 0;
    bit         model_live = 1'b0;
    bit         m_idle = 1'b1;
    bit         m_valid = 1'b0;
    bit         m_id = 1'b0, m_tie = 1'b0, m_early = 1'b0, m_run_early = 1'b0;
    logic [2:0] mb1 = 3'd0, mb2 = 3'd0, m_cnt1 = 3'd0, m_cnt2 = 3'd0, c1, c2;
    logic [8:0] exp_q[$];

    always @(posedge clk) begin
        cyc++;
        model_live = 1'b1;
        c1 = potential1_s - mb1;
        c2 = potential2_s - mb2;
        if (rst) begin
            m_idle = 1'b1; m_valid = 1'b0;
            m_cnt1 = 3'd0; m_cnt2 = 3'd0; m_id = 1'b0; m_tie = 1'b0; m_early = 1'b0;
            exp_q.delete();
        end else if (m_idle) begin
            if (start) begin
                m_idle = 1'b0; re = cyc + W; mb1 = potential1_s; mb2 = potential2_s;
                m_run_early = 1'b0;
            end
        end else if (m_valid) begin
            if (cls_ready) begin
                m_valid = 1'b0; m_idle = 1'b1;
            end
        end else begin
`ifdef CLS_EARLY_EXIT_EN
            if (cyc <= re && (c1 >= TH || c2 >= TH)) begin
                re = cyc; m_run_early = 1'b1;
            end
`endif
            if (cyc == re + 3) begin
                m_cnt1 = c1; m_cnt2 = c2; m_tie = (c1 == c2); m_id = (c2 > c1);
                m_early = m_run_early; m_valid = 1'b1;
                exp_q.push_back({m_early, m_tie, m_id, m_cnt2, m_cnt1});
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [8:0] exp_r;
    always @(negedge clk) begin
        if (model_live) begin
            check("en_s", en_s, (!m_idle && !m_valid && cyc < re));
            check("busy", busy, !m_idle);
            check("cls_valid", cls_valid, m_valid);
            check("cls_cnt1", cls_cnt1, m_cnt1);
            check("cls_cnt2", cls_cnt2, m_cnt2);
            check("cls_id", cls_id, m_id);
            check("cls_tie", cls_tie, m_tie);
            check("cls_early", cls_early, m_early);
            if (cls_valid && cls_ready) begin
                if (exp_q.size() == 0) begin
                    check("hs_unexpected", 1, 0);
                end else begin
                    exp_r = exp_q.pop_front();
                    check("hs_result", {cls_early, cls_tie, cls_id, cls_cnt2, cls_cnt1}, exp_r);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_run();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Applies one potential increment per set mask bit (bit k-1 = RUN cycle k).
    task automatic run_window(input logic [15:0] m1, input logic [15:0] m2, input int ncyc);
        for (int k = 1; k <= ncyc; k++) begin
            if (m1[k-1]) potential1_s = potential1_s + 3'd1;
            if (m2[k-1]) potential2_s = potential2_s + 3'd1;
            step(1);
        end
    endtask

    // n is the cycle number relative to the start edge t (cycle t+n ends at edge t+n).
    task automatic wait_valid(input int n0, output int n);
        n = n0;
        while (!cls_valid && n < n0 + 40) begin
            step(1);
            n++;
        end
        if (!cls_valid) check("valid_timeout", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    int n, vcount, last, pulses;
    bit saw_valid;

    initial begin
        step(3);
        check("rst_en_s", en_s, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", cls_valid, 0);
        check("rst_cnt1", cls_cnt1, 0);
        rst = 1'b0;
        step(1);

        // Baseline: neuron 1 at RUN cycles 2,5; neuron 2 at cycle 9.
        cls_ready = 1'b1;
        start_run();
        run_window(16'h0012, 16'h0100, W);
        wait_valid(W + 1, n);
        check("base_latency", n, 20);
        check("base_cnt1", cls_cnt1, 2);
        check("base_cnt2", cls_cnt2, 1);
        check("base_id", cls_id, 0);
        check("base_tie", cls_tie, 0);
        check("model_base_cnt1", m_cnt1, 2);
        step(1);
        check("base_valid_1cyc", cls_valid, 0);
        check("base_busy_fall", busy, 0);

        // Wrap: 6 -> 1 (3 events) and 7 -> 0 (1 event).
        potential1_s = 3'd6;
        potential2_s = 3'd7;
        step(1);
        start_run();
        run_window(16'h0015, 16'h0008, W);
        wait_valid(W + 1, n);
        check("wrap_cnt1", cls_cnt1, 3);
        check("wrap_cnt2", cls_cnt2, 1);
        check("wrap_id", cls_id, 0);
        check("model_wrap_cnt1", m_cnt1, 3);
        step(1);

        // Tie with backpressure, plus a start pulse during DONE that must be ignored.
        cls_ready = 1'b0;
        start_run();
        run_window(16'h0022, 16'h0204, W);
        wait_valid(W + 1, n);
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            if (cls_valid) vcount++;
            start = (i == 2);
            step(1);
        end
        start = 1'b0;
        cls_ready = 1'b1;
        if (cls_valid) vcount++;
        step(1);
        check("bp_valid_cycles", vcount, 6);
        check("tie_flag", cls_tie, 1);
        check("tie_id", cls_id, 0);
        check("tie_cnt1", cls_cnt1, 2);
        check("tie_cnt2", cls_cnt2, 2);
        step(2);
        check("done_start_ignored", busy, 0);

`ifdef CLS_EARLY_EXIT_EN
        // Early exit: neuron 2 reaches 4 events at RUN cycle 7.
        start_run();
        run_window(16'h0000, 16'h0055, 7);
        check("early_en_low", en_s, 0);
        wait_valid(8, n);
        check("early_id", cls_id, 1);
        check("early_flag", cls_early, 1);
        check("early_cnt2", cls_cnt2, 4);
        step(1);
`endif

        // Reset in RUN cycle 5 abandons the window.
        start_run();
        run_window(16'h0003, 16'h0000, 4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_rst_en_s", en_s, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", cls_valid, 0);
        saw_valid = 1'b0;
        for (int i = 0; i < W + 8; i++) begin
            if (cls_valid) saw_valid = 1'b1;
            step(1);
        end
        check("mid_rst_no_result", saw_valid, 0);
        start_run();
        run_window(16'h0001, 16'h0000, W);
        wait_valid(W + 1, n);
        check("post_rst_latency", n, W + 4);
        check("post_rst_cnt1", cls_cnt1, 1);
        step(1);

        // Back-to-back: start held high, ready high.
        cls_ready = 1'b1;
        start = 1'b1;
        last = -1;
        pulses = 0;
        for (int i = 0; i < 4 * (W + 5) + 6; i++) begin
            if (cls_valid) begin
                if (last >= 0) check("b2b_spacing", i - last, W + 5);
                last = i;
                pulses++;
            end
            if ($urandom_range(0, 3) == 0) potential1_s = potential1_s + 3'd1;
            if ($urandom_range(0, 4) == 0) potential2_s = potential2_s + 3'd1;
            step(1);
        end
        start = 1'b0;
        check("b2b_pulses", pulses, 4);

        // Randomized traffic against the model.
        for (int i = 0; i < 900; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            cls_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 2) == 0) potential1_s = potential1_s + 3'd1;
            if ($urandom_range(0, 2) == 0) potential2_s = potential2_s + 3'd1;
            step(1);
        end
        start = 1'b0;
        rst = 1'b0;
        cls_ready = 1'b1;
        step(W + 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
